uart_rx_frame_checker: RTL and testbench
========================================

# uart_rx_frame_checker

- Receive-side frame engine of the UART.
- Consumes one already-sampled line bit per bit period from the RX data sampler (`sampled_bit` qualified by `bit_valid`).
- Deserializes the frame LSB-first, checks the optional parity bit with the same even/odd convention the TX parity generator uses, and checks the stop bit.
- Hands a completed byte to the RX-side register/FIFO path with a one-cycle `data_valid` strobe plus error pulses.

## Interface
- `DATA_WIDTH`, default 8: number of data bits per frame; must be ≥ 2.
- `CLK`  in  1  system clock; all logic is rising-edge.
- `RST`  in  1  synchronous reset, active-high.
- `PAR_EN`  in  1  1 = frame carries a parity bit after the data bits.
- `PAR_TYP`  in  1  0 = even parity (bit = XOR of data), 1 = odd parity (bit = XNOR of data).
- `sampled_bit`  in  1  majority-voted line value for the current bit period.
- `bit_valid`  in  1  one-cycle strobe; `sampled_bit` is meaningful only in that cycle.
- `P_DATA`  out  DATA_WIDTH  last accepted data word; holds until the next accepted frame.
- `data_valid`  out  1  one-cycle pulse when a frame completes with no error.
- `par_err`  out  1  one-cycle pulse: parity mismatch in the frame just completed.
- `stp_err`  out  1  one-cycle pulse: stop bit sampled as 0.
- `busy`  out  1  high from start-bit acceptance until return to IDLE.

## Operation
- **FSM states:** IDLE, DATA, PARITY, STOP. The FSM advances only on cycles where `bit_valid` = 1. Other cycles hold all state.
- **IDLE**
  - `bit_valid` with `sampled_bit` = 0 → accept start bit, go to DATA.
  - Clear bit counter and shift register.
  - Latch `PAR_EN` / `PAR_TYP` into frame-config registers, used for the whole frame.
  - `sampled_bit` = 1 → stay in IDLE.
- **DATA**
  - Each strobe shifts `sampled_bit` into the MSB of the shift register, right-shifting, so the first data bit ends in bit 0.
  - The counter increments from 0.
  - On the strobe with counter = DATA_WIDTH−1 → PARITY if latched `PAR_EN`, else STOP.
- **PARITY**
  - Expected bit = XOR of the shift register; inverted if latched `PAR_TYP` = 1.
  - Mismatch sets an internal `par_fail` flag.
  - The next strobe moves to STOP.
- **STOP**
  - On the strobe, `sampled_bit` = 0 sets stop failure.
  - Always return to IDLE, with no extra idle-bit requirement; a start bit may be accepted on the very next strobe.
- **Completion** (same edge as the STOP strobe; outputs registered):
  - No failure: `P_DATA` ← shift register, `data_valid` = 1.
  - Any failure: `P_DATA` unchanged, `data_valid` = 0.
  - `par_err` = `par_fail`, `stp_err` = stop failure; both may assert together.
- Changes on `PAR_EN` / `PAR_TYP` mid-frame have no effect until the next start bit.
- **Reset values:** state IDLE, `P_DATA` = 0, `data_valid`/`par_err`/`stp_err`/`busy` = 0, counter/shift/`par_fail` = 0.
- **Reset mid-frame:** the frame is abandoned; no pulses are emitted.
- **Reset priority:** `RST` has priority over `bit_valid` in the same cycle.

## Timing
- Pulse outputs go high in the cycle after the STOP-state strobe edge and last exactly one cycle.
- `busy` rises the cycle after start acceptance and falls the cycle after the STOP strobe.
- **Frame strobe counts,** start strobe to completion edge:
  - PAR_EN = 1: DATA_WIDTH+2 strobes.
  - PAR_EN = 0: DATA_WIDTH+1 strobes.
- `bit_valid` may be asserted every cycle (back-to-back strobes). The block must then sustain one bit per clock with no stall.
- **Consecutive frames:** if a start strobe arrives on the strobe immediately after STOP, `busy` stays high or re-rises one cycle later. The completion pulses of the prior frame are still emitted.

## Structure
- **Shared package `uart_pkg`:**
  - FSM state encoding (2-bit enumerated constants IDLE/DATA/PARITY/STOP).
  - Parity-type constants (EVEN = 0, ODD = 1).
  - These are shared with the TX FSM.
- **Sub-module `uart_rx_parity_check`:**
  - Combinational.
  - Inputs: data word, received parity bit, `PAR_TYP`.
  - Output: mismatch flag.
  - Kept separate so it mirrors the TX parity generator and is reusable by a later loopback checker.
- Counter width is $clog2(DATA_WIDTH).

## Test plan
- **Even-parity frame.** PAR_EN = 1, PAR_TYP = 0. Frame 0, data 0xA5 LSB-first, parity 0, stop 1, strobes every 16 cycles.
  - → `P_DATA` = 0xA5, `data_valid` one-cycle pulse, no errors.
- **Odd-parity mismatch.** PAR_EN = 1, PAR_TYP = 1, data 0x0F, parity bit 0 sent (expected 1).
  - → `par_err` pulse, `data_valid` = 0, `P_DATA` retains the previous value.
- **Stop-bit error, no parity.** PAR_EN = 0, data 0x3C, stop bit 0.
  - → `stp_err` pulse after 9 strobes from start, `data_valid` = 0, FSM in IDLE.
- **Back-to-back frames.** `bit_valid` held high every cycle, frames 0x01 then 0xFE with PAR_EN = 1.
  - → two `data_valid` pulses 11 cycles apart, `P_DATA` 0x01 then 0xFE.
- **Reset mid-frame.** Assert `RST` after the 4th data strobe, then send a clean 0x55 frame.
  - → no pulses from the aborted frame; 0x55 received correctly.
- **Config change mid-frame.** Toggle PAR_TYP during DATA.
  - → parity checked with the value latched at start; no false `par_err`.

Source files
------------

// File: rtl/uart_pkg.sv
// Definitions shared by the UART RX frame checker and the TX FSM:
// the frame state encoding and the parity-type constants.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } uart_state_e;

  localparam logic EVEN = 1'b0;
  localparam logic ODD  = 1'b1;

  // Parity bit a transmitter places after the data bits.
  function automatic logic gen_parity(input logic data_xor, input logic par_typ);
    return data_xor ^ (par_typ == ODD);
  endfunction

endpackage

// File: rtl/uart_rx_parity_check.sv
// Combinational parity checker: flags a received parity bit that disagrees with
// the bit the TX parity generator would have produced for the same word.
module uart_rx_parity_check
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  par_bit,
  input  logic                  par_typ,
  output logic                  par_mismatch
);

  assign par_mismatch = par_bit ^ gen_parity(^data, par_typ);

endmodule

// File: rtl/uart_rx_frame_checker.sv
// UART receive frame engine: deserializes sampled bits LSB-first, checks parity
// and stop bit, and emits a registered data word with one-cycle status pulses.
module uart_rx_frame_checker
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  sampled_bit,
  input  logic                  bit_valid,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stp_err,
  output logic                  busy
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  uart_state_e           state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  par_en_q, par_en_d;
  logic                  par_typ_q, par_typ_d;
  logic                  par_fail_q, par_fail_d;
  logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
  logic                  data_valid_q, data_valid_d;
  logic                  par_err_q, par_err_d;
  logic                  stp_err_q, stp_err_d;
  logic                  busy_q, busy_d;
  logic                  par_mismatch;

  uart_rx_parity_check #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_parity_check (
    .data        (shift_q),
    .par_bit     (sampled_bit),
    .par_typ     (par_typ_q),
    .par_mismatch(par_mismatch)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    shift_d      = shift_q;
    par_en_d     = par_en_q;
    par_typ_d    = par_typ_q;
    par_fail_d   = par_fail_q;
    p_data_d     = p_data_q;
    data_valid_d = 1'b0;
    par_err_d    = 1'b0;
    stp_err_d    = 1'b0;

    if (bit_valid) begin
      unique case (state_q)
        IDLE: begin
          if (!sampled_bit) begin
            // Frame config is frozen here so mid-frame changes cannot corrupt it.
            state_d    = DATA;
            cnt_d      = '0;
            shift_d    = '0;
            par_en_d   = PAR_EN;
            par_typ_d  = PAR_TYP;
            par_fail_d = 1'b0;
          end
        end
        DATA: begin
          shift_d = {sampled_bit, shift_q[DATA_WIDTH-1:1]};
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == LAST_BIT) begin
            cnt_d   = '0;
            state_d = par_en_q ? PARITY : STOP;
          end
        end
        PARITY: begin
          par_fail_d = par_mismatch;
          state_d    = STOP;
        end
        STOP: begin
          state_d   = IDLE;
          par_err_d = par_fail_q;
          stp_err_d = !sampled_bit;
          if (!par_fail_q && sampled_bit) begin
            p_data_d     = shift_q;
            data_valid_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      shift_q      <= '0;
      par_en_q     <= 1'b0;
      par_typ_q    <= 1'b0;
      par_fail_q   <= 1'b0;
      p_data_q     <= '0;
      data_valid_q <= 1'b0;
      par_err_q    <= 1'b0;
      stp_err_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      shift_q      <= shift_d;
      par_en_q     <= par_en_d;
      par_typ_q    <= par_typ_d;
      par_fail_q   <= par_fail_d;
      p_data_q     <= p_data_d;
      data_valid_q <= data_valid_d;
      par_err_q    <= par_err_d;
      stp_err_q    <= stp_err_d;
      busy_q       <= busy_d;
    end
  end

  assign P_DATA     = p_data_q;
  assign data_valid = data_valid_q;
  assign par_err    = par_err_q;
  assign stp_err    = stp_err_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_uart_rx_frame_checker.sv
// Self-checking bench for uart_rx_frame_checker: directed vector table, hand
// sequences for back-to-back/reset corners, and randomized frames vs a model.
module tb_uart_rx_frame_checker;

  logic       CLK;
  logic       RST;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic       sampled_bit;
  logic       bit_valid;
  logic [7:0] P_DATA;
  logic       data_valid;
  logic       par_err;
  logic       stp_err;
  logic       busy;

  uart_rx_frame_checker #(.DATA_WIDTH(8)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .sampled_bit(sampled_bit),
    .bit_valid  (bit_valid),
    .P_DATA     (P_DATA),
    .data_valid (data_valid),
    .par_err    (par_err),
    .stp_err    (stp_err),
    .busy       (busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int n_pulses = 0;
  int dv_cyc[$];
  logic [7:0] dv_dat[$];

  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    if (data_valid) begin
      dv_cyc.push_back(cyc);
      dv_dat.push_back(P_DATA);
    end
    n_pulses = n_pulses + int'(data_valid) + int'(par_err) + int'(stp_err);
  end

  typedef struct {
    logic       pe;
    logic       pt;
    logic [7:0] data;
    logic       flip;
    logic       stop;
    int         gap;
    logic       tog;
    logic       exp_dv;
    logic       exp_pe;
    logic       exp_se;
    logic [7:0] exp_pdata;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic strobe(input logic b);
    sampled_bit = b;
    bit_valid   = 1'b1;
    @(posedge CLK);
    #1;
    bit_valid   = 1'b0;
    sampled_bit = 1'b1;
  endtask

  // Sends start, data LSB-first, optional parity, stop; returns just after the stop edge.
  task automatic send_frame(input logic [7:0] d, input logic pe, input logic pt,
                            input logic par_bit, input logic stop, input int gap,
                            input logic tog);
    PAR_EN  = pe;
    PAR_TYP = pt;
    strobe(1'b0);
    check("busy_after_start", busy, 1'b1);
    idle(gap);
    for (int i = 0; i < 8; i++) begin
      strobe(d[i]);
      if (tog && i == 3) begin
        PAR_EN  = ~pe;
        PAR_TYP = ~pt;
      end
      idle(gap);
    end
    if (pe) begin
      strobe(par_bit);
      idle(gap);
    end
    strobe(stop);
  endtask

  logic [7:0] model_pdata;
  int         n0;

  initial begin
    RST = 1'b1; PAR_EN = 1'b0; PAR_TYP = 1'b0; sampled_bit = 1'b1; bit_valid = 1'b0;

    vecs[0] = '{1'b1, 1'b0, 8'hA5, 1'b0, 1'b1, 15, 1'b0, 1'b1, 1'b0, 1'b0, 8'hA5};
    vecs[1] = '{1'b1, 1'b1, 8'h0F, 1'b1, 1'b1, 2,  1'b0, 1'b0, 1'b1, 1'b0, 8'hA5};
    vecs[2] = '{1'b0, 1'b0, 8'h3C, 1'b0, 1'b0, 3,  1'b0, 1'b0, 1'b0, 1'b1, 8'hA5};
    vecs[3] = '{1'b1, 1'b0, 8'h5A, 1'b0, 1'b1, 2,  1'b1, 1'b1, 1'b0, 1'b0, 8'h5A};
    vecs[4] = '{1'b1, 1'b1, 8'h0F, 1'b1, 1'b0, 1,  1'b0, 1'b0, 1'b1, 1'b1, 8'h5A};
    vecs[5] = '{1'b0, 1'b1, 8'hC3, 1'b0, 1'b1, 0,  1'b0, 1'b1, 1'b0, 1'b0, 8'hC3};

    idle(3);
    check("rst_pdata", P_DATA, 8'h00);
    check("rst_dv", data_valid, 1'b0);
    check("rst_par_err", par_err, 1'b0);
    check("rst_stp_err", stp_err, 1'b0);
    check("rst_busy", busy, 1'b0);
    RST = 1'b0;
    idle(2);

    // Directed vector table
    for (int i = 0; i < 6; i++) begin
      send_frame(vecs[i].data, vecs[i].pe, vecs[i].pt,
                 (^vecs[i].data) ^ vecs[i].pt ^ vecs[i].flip,
                 vecs[i].stop, vecs[i].gap, vecs[i].tog);
      check($sformatf("v%0d_dv", i), data_valid, vecs[i].exp_dv);
      check($sformatf("v%0d_par_err", i), par_err, vecs[i].exp_pe);
      check($sformatf("v%0d_stp_err", i), stp_err, vecs[i].exp_se);
      check($sformatf("v%0d_pdata", i), P_DATA, vecs[i].exp_pdata);
      check($sformatf("v%0d_busy_end", i), busy, 1'b0);
      idle(1);
      check($sformatf("v%0d_pulse_len", i), {data_valid, par_err, stp_err}, 3'b000);
      $display("vec %0d: data=%02h pe=%0b pt=%0b -> P_DATA=%02h", i, vecs[i].data,
               vecs[i].pe, vecs[i].pt, P_DATA);
      idle(2);
    end

    // Back-to-back frames, bit_valid every cycle
    dv_cyc.delete();
    dv_dat.delete();
    send_frame(8'h01, 1'b1, 1'b0, 1'b1, 1'b1, 0, 1'b0);
    send_frame(8'hFE, 1'b1, 1'b0, 1'b1, 1'b1, 0, 1'b0);
    idle(2);
    check("b2b_count", dv_cyc.size(), 2);
    if (dv_cyc.size() >= 2) begin
      check("b2b_spacing", dv_cyc[1] - dv_cyc[0], 11);
      check("b2b_first", dv_dat[0], 8'h01);
      check("b2b_second", dv_dat[1], 8'hFE);
    end
    $display("b2b: %0d data_valid pulses", dv_cyc.size());

    // Reset mid-frame, with a start-like strobe colliding with reset
    n0 = n_pulses;
    PAR_EN = 1'b1; PAR_TYP = 1'b0;
    strobe(1'b0);
    for (int i = 0; i < 4; i++) strobe(1'b1);
    RST = 1'b1; bit_valid = 1'b1; sampled_bit = 1'b0;
    @(posedge CLK);
    #1;
    RST = 1'b0; bit_valid = 1'b0; sampled_bit = 1'b1;
    check("rstmid_busy", busy, 1'b0);
    check("rstmid_pdata", P_DATA, 8'h00);
    idle(20);
    check("rstmid_no_pulses", n_pulses, n0);
    send_frame(8'h55, 1'b1, 1'b0, 1'b0, 1'b1, 1, 1'b0);
    check("rstmid_dv", data_valid, 1'b1);
    check("rstmid_pdata55", P_DATA, 8'h55);
    $display("reset mid-frame: recovered P_DATA=%02h", P_DATA);
    idle(1);

    // Randomized frames against a rule-level model
    model_pdata = 8'h55;
    for (int t = 0; t < 40; t++) begin
      logic [7:0] d;
      logic pe, pt, pb, stop, pfail, exp_dv;
      int gap, lead, ones;
      d    = 8'($urandom);
      pe   = 1'($urandom);
      pt   = 1'($urandom);
      pb   = 1'($urandom);
      stop = ($urandom_range(0, 4) != 0);
      gap  = $urandom_range(0, 2);
      lead = $urandom_range(0, 2);
      for (int k = 0; k < lead; k++) strobe(1'b1);
      check($sformatf("r%0d_idle_busy", t), busy, 1'b0);
      send_frame(d, pe, pt, pb, stop, gap, 1'($urandom));
      ones   = $countones(d);
      pfail  = pe && (((ones + int'(pb)) % 2) != int'(pt));
      exp_dv = !pfail && stop;
      if (exp_dv) model_pdata = d;
      check($sformatf("r%0d_dv", t), data_valid, exp_dv);
      check($sformatf("r%0d_par_err", t), par_err, pfail);
      check($sformatf("r%0d_stp_err", t), stp_err, !stop);
      check($sformatf("r%0d_pdata", t), P_DATA, model_pdata);
      $display("rand %0d: data=%02h pe=%0b pt=%0b pb=%0b stop=%0b -> dv=%0b perr=%0b serr=%0b",
               t, d, pe, pt, pb, stop, data_valid, par_err, stp_err);
      if ($urandom_range(0, 1) == 1) idle(1);
    end

    idle(3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
